// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - button synchroniser, debouncer and play validator feeding the game datapath
module detector_jogada #(
   parameter int DEBOUNCE_CICLOS = 5
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes,
   input  logic       habilita,
   output logic [3:0] jogada,
   output logic       tem_jogada,
   output logic       jogada_invalida,
   output logic [2:0] db_estado
);

   localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
   localparam logic [CW-1:0] CNT_FIM = CW'(DEBOUNCE_CICLOS - 1);

   localparam logic [2:0] ESPERA = 3'd0;
   localparam logic [2:0] FILTRA = 3'd1;
   localparam logic [2:0] ACEITA = 3'd2;
   localparam logic [2:0] SEGURA = 3'd3;
   localparam logic [2:0] SOLTA  = 3'd4;

   logic [3:0]    sync1;
   logic [3:0]    s;
   logic [3:0]    cand;
   logic [CW-1:0] cnt;
   logic [2:0]    estado;
   logic [2:0]    prox;
   logic          cand_onehot;
   logic          cnt_fim;

   assign cand_onehot = (cand != 4'd0) && ((cand & (cand - 4'd1)) == 4'd0);
   assign cnt_fim     = (cnt == CNT_FIM);

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1 <= 4'd0;
         s     <= 4'd0;
      end else begin
         sync1 <= botoes;
         s     <= sync1;
      end
   end

   // habilita only gates the arming path; once accepted, release tracking always runs
   always_comb begin
      prox = estado;
      case (estado)
         ESPERA: if (habilita && (s != 4'd0)) prox = FILTRA;
         FILTRA: begin
            if ((s != cand) || !habilita) prox = ESPERA;
            else if (cnt_fim)             prox = ACEITA;
         end
         ACEITA: prox = SEGURA;
         SEGURA: if (s == 4'd0) prox = SOLTA;
         SOLTA: begin
            if (s != 4'd0)   prox = SEGURA;
            else if (cnt_fim) prox = ESPERA;
         end
         default: prox = ESPERA;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         estado <= ESPERA;
      end else begin
         estado <= prox;
      end
   end

   // counter saturates at its terminal value so it can never wrap back into range
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt <= '0;
      end else begin
         case (estado)
            ESPERA: if (prox == FILTRA) cnt <= '0;
            FILTRA: if ((prox == FILTRA) && !cnt_fim) cnt <= cnt + 1'b1;
            SEGURA: if (s == 4'd0) cnt <= '0;
            SOLTA:  if ((prox == SOLTA) && !cnt_fim) cnt <= cnt + 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cand <= 4'd0;
      end else if ((estado == ESPERA) && (prox == FILTRA)) begin
         cand <= s;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         jogada <= 4'd0;
      end else if ((estado == ACEITA) && cand_onehot) begin
         jogada <= cand;
      end
   end

   assign tem_jogada      = (estado == ACEITA) && cand_onehot;
   assign jogada_invalida = (estado == ACEITA) && !cand_onehot;
   assign db_estado       = estado;

endmodule

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Input-conditioning stage directly upstream of the game datapath/FSM.
- Takes the raw `botoes` bus and performs two-flop synchronisation, debouncing, and validity checking.
- Emits one registered play value plus a single-cycle `tem_jogada` pulse per physical press, which feeds the play register and comparator.
- Re-arms only after a debounced release, so a long press never produces repeated plays.

Parameters:
- DEBOUNCE_CICLOS, 5, number of consecutive stable samples required to accept a press or a release (must be >= 1). At the 1 kHz system clock, 5 = 5 ms.

Ports:
- clock  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- botoes  input  4  raw asynchronous button lines, active-high
- habilita  input  1  1 = presses may be accepted; 0 = new presses are ignored
- jogada  output  4  registered one-hot value of the last accepted valid play
- tem_jogada  output  1  one-cycle pulse when a valid play is accepted
- jogada_invalida  output  1  one-cycle pulse when a debounced press has 0 or more than 1 bits set
- db_estado  output  3  current FSM state code, for debug display

Behaviour:
- Synchroniser: two flops, sync1 <= botoes and s <= sync1. The FSM reads only s. Both flops clear on reset.
- Counter `cnt`: width $clog2(DEBOUNCE_CICLOS+1); it saturates and never wraps.
- `cand`: 4-bit register holding the candidate press.
- FSM states and codes: ESPERA=0, FILTRA=1, ACEITA=2, SEGURA=3, SOLTA=4. Unused codes go to ESPERA.
- ESPERA:
  - If habilita=1 and s!=0: cand<=s, cnt<=0, go to FILTRA.
  - Otherwise stay.
- FILTRA:
  - If s!=cand or habilita=0: go to ESPERA (bounce or abort).
  - Else if cnt==DEBOUNCE_CICLOS-1: go to ACEITA.
  - Else cnt<=cnt+1.
- ACEITA (exactly one cycle, ignores habilita):
  - If cand is one-hot: jogada<=cand, and tem_jogada=1 during this cycle.
  - Else: jogada_invalida=1 during this cycle, and jogada is unchanged.
  - Next state is SEGURA.
- SEGURA:
  - If s==0: cnt<=0, go to SOLTA.
  - Otherwise stay; the press is held and there are no further pulses.
- SOLTA:
  - If s!=0: go to SEGURA (release bounce).
  - Else if cnt==DEBOUNCE_CICLOS-1: go to ESPERA.
  - Else cnt<=cnt+1.
- Pulse outputs: tem_jogada and jogada_invalida are Moore outputs decoded from state ACEITA and cand. They are never both 1, and each is high for exactly one cycle per accepted press.
- Latency:
  - Let edge k be the first rising edge at which botoes holds its final stable value.
  - The press is accepted only if botoes stays constant through edge k+DEBOUNCE_CICLOS, i.e. DEBOUNCE_CICLOS+1 consecutive samples.
  - The pulse is high in the cycle after edge k+DEBOUNCE_CICLOS+2. With the default, that is 7 edges after k.
- Release: DEBOUNCE_CICLOS+1 consecutive zero samples are required before the block re-arms.
- Button changes while in SEGURA, e.g. a second button added, are ignored until a full release.
- habilita: falling to 0 aborts only ESPERA/FILTRA. ACEITA, SEGURA and SOLTA always complete, so release tracking is never lost.
- Reset values:
  - Outputs: jogada=0000, tem_jogada=0, jogada_invalida=0, db_estado=0.
  - Internal: sync flops=0, cand=0, cnt=0.
- Reset mid-operation: state returns to ESPERA and jogada clears. A button still held after reset is seen as a fresh press and is accepted again after the normal latency.
- Reset has priority over every transition in the same cycle.

Test Plan:
- Reset, then 10 idle cycles with botoes=0000, habilita=1 -> all outputs 0, db_estado=0 throughout.
- botoes=0001 held 10 cycles, then 0000 -> exactly one tem_jogada pulse, 7 cycles after the first sampling edge. jogada=0001 persists after release; db_estado sequence is 0,1,2,3,4,0.
- botoes=0010 for 3 cycles, 0000 for 2, then 0010 for 10 -> only one pulse, timed from the start of the final stable interval; jogada=0010.
- After jogada=0010, botoes=0110 held 10 cycles -> one jogada_invalida pulse, no tem_jogada, jogada stays 0010.
- Press 0100 for 10 cycles with habilita=0 -> no pulses, db_estado stays 0. Then habilita=1 and press 1000 -> pulse, jogada=1000.
- Hold 1000, assert reset for 1 cycle while in SEGURA -> jogada=0000 and db_estado=0 on the next edge. With 1000 still held, a new tem_jogada pulse arrives 7 cycles after reset release (DEBOUNCE_CICLOS=5).
- Back-to-back presses 0001, 0010, 0100 at 10-cycle hold / 10-cycle gap -> exactly three pulses, with jogada following each value.
